// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift sequencer state encoding, shift-unit
// function codes and default datapath widths.
package alu_pkg;

  localparam int IN_OUT_W  = 16;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WAIT = 2'b10
  } state_t;

  localparam logic [3:0] FUN_SHR = 4'b1100;
  localparam logic [3:0] FUN_SHL = 4'b1101;

  // Map a shift direction (0 = right, 1 = left) to the shift-unit function code.
  function automatic logic [3:0] fun_for_dir(input logic dir);
    logic [3:0] fun;
    if (dir) begin
      fun = FUN_SHL;
    end else begin
      fun = FUN_SHR;
    end
    return fun;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// Multi-bit shift sequencer: iterates a single-bit registered shift unit
// N times (N = 0..2**CNT_W-1), feeding each result back as the next operand,
// then returns the final word with a one-cycle Done pulse.
module shift_seq_ctrl
  import alu_pkg::*;
#(
  parameter int In_out = IN_OUT_W,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              Dir,
  input  logic [In_out-1:0] Op_In,
  input  logic [CNT_W-1:0]  Shift_Amt,
  output logic              Busy,
  output logic              Done,
  output logic [In_out-1:0] Result,
  output logic              Flag_Err,
  output logic [In_out-1:0] Sh_A,
  output logic [In_out-1:0] Sh_B,
  output logic [3:0]        Sh_FUN,
  output logic              Sh_Enable,
  input  logic [In_out-1:0] Sh_OUT,
  input  logic              Sh_Flag
);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [In_out-1:0] WORD_ZERO = {In_out{1'b0}};

  state_t              state;
  state_t              next_state;
  logic [In_out-1:0]   op_latch;
  logic                dir_latch;
  logic [CNT_W-1:0]    remaining;
  logic                first_step;
  logic                bypass;
  logic                sticky_err;
  logic                step_bad;

  // A step issued in the previous cycle reports its flag now: every RUN cycle
  // except the first, and WAIT unless the zero-amount bypass is active.
  always_comb begin
    step_bad = 1'b0;
    if (state == RUN) begin
      step_bad = !first_step && !Sh_Flag;
    end else if (state == WAIT) begin
      step_bad = !bypass && !Sh_Flag;
    end else begin
      step_bad = 1'b0;
    end
  end

  // State register; reset abandons any command in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: zero amounts skip RUN, last step moves to WAIT.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (Start) begin
          if (Shift_Amt == CNT_ZERO) begin
            next_state = WAIT;
          end else begin
            next_state = RUN;
          end
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (remaining == CNT_ONE) begin
          next_state = WAIT;
        end else begin
          next_state = RUN;
        end
      end
      WAIT:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shift-unit drive decoded from the state; operand is fed back after step one.
  always_comb begin
    Busy      = (state != IDLE);
    Sh_Enable = 1'b0;
    Sh_A      = WORD_ZERO;
    Sh_B      = WORD_ZERO;
    Sh_FUN    = FUN_SHR;
    case (state)
      RUN: begin
        Sh_Enable = 1'b1;
        Sh_FUN    = fun_for_dir(dir_latch);
        if (first_step) begin
          Sh_A = op_latch;
        end else begin
          Sh_A = Sh_OUT;
        end
      end
      IDLE:    Sh_Enable = 1'b0;
      WAIT:    Sh_Enable = 1'b0;
      default: Sh_Enable = 1'b0;
    endcase
  end

  // Command latch, step counter, sticky error and registered completion outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_latch   <= WORD_ZERO;
      dir_latch  <= 1'b0;
      remaining  <= CNT_ZERO;
      first_step <= 1'b0;
      bypass     <= 1'b0;
      sticky_err <= 1'b0;
      Done       <= 1'b0;
      Result     <= WORD_ZERO;
      Flag_Err   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            op_latch   <= Op_In;
            dir_latch  <= Dir;
            remaining  <= Shift_Amt;
            first_step <= (Shift_Amt != CNT_ZERO);
            bypass     <= (Shift_Amt == CNT_ZERO);
            sticky_err <= 1'b0;
          end
        end
        RUN: begin
          remaining  <= remaining - CNT_ONE;
          first_step <= 1'b0;
          if (step_bad) begin
            sticky_err <= 1'b1;
          end
        end
        WAIT: begin
          if (bypass) begin
            Result <= op_latch;
          end else begin
            Result <= Sh_OUT;
          end
          Done       <= 1'b1;
          Flag_Err   <= sticky_err | step_bad;
          sticky_err <= sticky_err | step_bad;
        end
        default: begin
          Done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with a behavioural single-bit
// shift unit (registered, active-low reset) closing the feedback loop.
module tb_shift_seq_ctrl;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic        Dir;
  logic [15:0] Op_In;
  logic [3:0]  Shift_Amt;
  logic        Busy;
  logic        Done;
  logic [15:0] Result;
  logic        Flag_Err;
  logic [15:0] Sh_A;
  logic [15:0] Sh_B;
  logic [3:0]  Sh_FUN;
  logic        Sh_Enable;
  logic [15:0] Sh_OUT;
  logic        Sh_Flag;
  logic        sh_rst_n;
  logic        bad_now;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  shift_seq_ctrl #(.In_out(16), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Dir(Dir), .Op_In(Op_In),
    .Shift_Amt(Shift_Amt), .Busy(Busy), .Done(Done), .Result(Result),
    .Flag_Err(Flag_Err), .Sh_A(Sh_A), .Sh_B(Sh_B), .Sh_FUN(Sh_FUN),
    .Sh_Enable(Sh_Enable), .Sh_OUT(Sh_OUT), .Sh_Flag(Sh_Flag)
  );

  assign sh_rst_n = ~RST;

  // Single-bit logical shift unit with 1-cycle latency; bad_now spoils the flag.
  always @(posedge CLK or negedge sh_rst_n) begin
    if (!sh_rst_n) begin
      Sh_OUT  <= 16'h0000;
      Sh_Flag <= 1'b0;
    end else if (Sh_Enable) begin
      Sh_OUT  <= (Sh_FUN == 4'b1101) ? (Sh_A << 1) : (Sh_A >> 1);
      Sh_Flag <= ~bad_now;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command from a negedge and follow it to Done; returns at the Done
  // negedge so a following call exercises Start coincident with Done.
  // inj = index of the step whose flag is spoiled (>= amt means none).
  task automatic run_cmd(input logic [15:0] op, input logic d, input logic [3:0] amt,
                         input int inj, input bit dup);
    logic [15:0] exp_res;
    logic [15:0] exp_a;
    int cyc, en_cnt, busy_cnt;
    bit seen_done;
    exp_res = d ? (op << amt) : (op >> amt);
    Start = 1'b1; Op_In = op; Dir = d; Shift_Amt = amt;
    @(posedge CLK);
    cyc = 0; en_cnt = 0; busy_cnt = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (dup && cyc == 1) begin
        Start = 1'b1; Op_In = 16'h0000; Dir = ~d; Shift_Amt = 4'd1;
      end else begin
        Start = 1'b0;
      end
      if (Done) begin
        seen_done = 1'b1;
      end else begin
        if (Busy) busy_cnt++;
        if (Sh_Enable) begin
          exp_a = d ? (op << en_cnt) : (op >> en_cnt);
          check("sh_a", Sh_A, exp_a);
          check("sh_fun", Sh_FUN, d ? 4'b1101 : 4'b1100);
          bad_now = (en_cnt == inj);
          en_cnt++;
        end else begin
          check("sh_idle_a", Sh_A, 16'h0000);
          bad_now = 1'b0;
        end
        check("sh_b", Sh_B, 16'h0000);
      end
    end
    bad_now = 1'b0;
    Start = 1'b0;
    check("done_seen", seen_done, 1'b1);
    check("done_edges", cyc - 1, amt + 1);
    check("busy_cycles", busy_cnt, amt + 1);
    check("steps", en_cnt, amt);
    check("result", Result, exp_res);
    check("flag_err", Flag_Err, (inj < int'(amt)) ? 1'b1 : 1'b0);
    check("busy_at_done", Busy, 1'b0);
  endtask

  // Idle for n cycles and confirm outputs hold with no stray Done.
  task automatic idle_hold(input int n);
    logic [15:0] r;
    logic f;
    r = Result; f = Flag_Err;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("idle_done", Done, 1'b0);
      check("idle_busy", Busy, 1'b0);
      check("hold_result", Result, r);
      check("hold_flag", Flag_Err, f);
    end
  endtask

  initial begin
    logic [15:0] op;
    logic [3:0]  amt;
    logic        d;
    int          inj;
    bit          got_done;

    RST = 1'b1; Start = 1'b0; Dir = 1'b0; Op_In = 16'h0000; Shift_Amt = 4'd0; bad_now = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_result", Result, 16'h0000);
    check("rst_flag", Flag_Err, 1'b0);
    check("rst_enable", Sh_Enable, 1'b0);
    check("rst_fun", Sh_FUN, 4'b1100);
    RST = 1'b0;
    @(negedge CLK);

    run_cmd(16'h00F0, 1'b0, 4'd4, 99, 1'b0);
    check("t1_value", Result, 16'h000F);
    run_cmd(16'h0001, 1'b1, 4'd15, 99, 1'b0);
    check("t2_value", Result, 16'h8000);
    run_cmd(16'h1234, 1'b0, 4'd0, 99, 1'b0);
    check("t3_value", Result, 16'h1234);
    idle_hold(2);
    run_cmd(16'hFFFF, 1'b1, 4'd3, 99, 1'b1);
    check("t4_value", Result, 16'hFFF8);
    run_cmd(16'hA5A5, 1'b0, 4'd5, 2, 1'b0);
    check("t5_err", Flag_Err, 1'b1);
    run_cmd(16'h5A5A, 1'b1, 4'd5, 99, 1'b0);
    check("t5_clean", Flag_Err, 1'b0);
    run_cmd(16'h0F0F, 1'b1, 4'd6, 5, 1'b0);
    idle_hold(1);

    // Reset in the middle of an 8-step command.
    Start = 1'b1; Op_In = 16'hABCD; Dir = 1'b1; Shift_Amt = 4'd8;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    check("mid_rst_busy", Busy, 1'b0);
    check("mid_rst_done", Done, 1'b0);
    check("mid_rst_result", Result, 16'h0000);
    check("mid_rst_flag", Flag_Err, 1'b0);
    check("mid_rst_enable", Sh_Enable, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (Done) got_done = 1'b1;
    end
    check("no_done_after_rst", got_done, 1'b0);
    run_cmd(16'h8000, 1'b0, 4'd1, 99, 1'b0);
    check("t6_value", Result, 16'h4000);

    // Randomized commands, some back-to-back, some with idle gaps.
    for (int n = 0; n < 24; n++) begin
      op  = 16'($urandom);
      amt = 4'($urandom_range(0, 15));
      d   = 1'($urandom_range(0, 1));
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 99;
      run_cmd(op, d, amt, inj, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_hold(int'($urandom_range(1, 3)));
    end
    idle_hold(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
